alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have parameter: ALU_LAT, 1, cycles from operand issue to result sample (1..15).
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports, per requester n in {0,1}: reqn_valid input 1; reqn_ready output 1; reqn_op input 4 (ALU control code); reqn_a input WIDTH; reqn_b input WIDTH.
REQ-006 SHALL have ports, per requester n: rspn_valid output 1; rspn_ready input 1; rspn_data output WIDTH; rspn_err output 1.
REQ-007 SHALL have ports: alu_ctrl output 4; alu_a output WIDTH; alu_b output WIDTH; alu_result input WIDTH (shared ALU, combinational from alu_ctrl/alu_a/alu_b).
REQ-008 SHALL have port: busy output 1, high in any state other than IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-010 IDLE: reqn_ready SHALL be high only for the requester selected by arbitration; both low when neither valid.
REQ-011 Arbitration SHALL be round-robin: single valid requester wins; both valid -> requester not served last wins; last-served pointer resets to 1 (requester 0 wins first contention).
REQ-012 Accept = reqn_valid & reqn_ready in IDLE; op, a, b, requester id SHALL be latched on the accept edge; pointer updates on accept.
REQ-013 Valid ops: 4'b0000..4'b0111 (COMP, AND, XOR, OR, DEC, ADD, SUB, INC); accept of valid op SHALL go IDLE -> EXEC.
REQ-014 Accept of op 4'b1000..4'b1111 SHALL go IDLE -> RESP directly, rsp_data = 0, rsp_err = 1; ALU never driven.
REQ-015 EXEC: alu_ctrl/alu_a/alu_b SHALL carry latched values, stable for ALU_LAT cycles; 4-bit counter counts ALU_LAT cycles; on last EXEC cycle alu_result SHALL be registered into rsp_data, -> RESP.
REQ-016 Outside EXEC, alu_ctrl SHALL be 4'b0000 and alu_a/alu_b SHALL be 0.
REQ-017 Accept-to-rspn_valid latency SHALL be ALU_LAT+1 cycles (valid op), 1 cycle (invalid op).
REQ-018 RESP: rspn_valid high only for served requester; rspn_data/rspn_err held stable until rspn_ready; rspn_valid & rspn_ready -> IDLE next cycle.
REQ-019 No new accept SHALL occur in EXEC or RESP; reqn_ready low there; requests wait, not dropped.
REQ-020 Back-to-back: minimum accept-to-accept spacing ALU_LAT+2 cycles with rspn_ready held high.
REQ-021 rspn_ready asserted by non-served requester SHALL be ignored.
REQ-022 reqn_valid deasserted while ready low SHALL have no effect; reqn_op/a/b changes after accept SHALL not affect the transaction.
REQ-023 Result SHALL be alu_result truncated/held at WIDTH bits; no carry/overflow output.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, counter 0, pointer 1, all reqn_ready 0, rspn_valid 0, rspn_data 0, rspn_err 0, alu_ctrl 0, alu_a 0, alu_b 0, busy 0.
REQ-025 Reset during EXEC or RESP SHALL abort the transaction with no response ever issued.
REQ-026 First accept possible on first rising edge after rst_n deassertion.

Verification
REQ-027 ALU_LAT=1, req0 valid op 4'b0101 a=5 b=7, rsp0_ready=1 -> alu_ctrl=0101 one cycle, rsp0_valid 2 cycles after accept, rsp0_data=12, rsp0_err=0.
REQ-028 req0 and req1 valid continuously, same cycle -> grants 0,1,0,1; each rspn_valid only for its requester.
REQ-029 req1 op 4'b1111 -> rsp1_valid 1 cycle after accept, rsp1_data=0, rsp1_err=1, alu_ctrl stays 0000.
REQ-030 ALU_LAT=3, req0 op 4'b0110 a=10 b=3, rsp0_ready low 4 cycles -> alu inputs stable 3 cycles, rsp0_data=7 held stable, busy high throughout, req1 ready low until handshake.
REQ-031 rst_n pulsed low mid-EXEC -> all outputs 0 asynchronously, no rspn_valid afterward; next contention grants req0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One transaction in flight; result held in RESP until the served requester takes it.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             sel_q, sel_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic grant0, grant1;

  // ptr_q holds the id of the last requester served; on contention the other one wins.
  assign grant0 = req0_valid & (~req1_valid | ptr_q);
  assign grant1 = req1_valid & (~req0_valid | ~ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      sel_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    data_d     = data_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_ctrl   = 4'b0000;
    alu_a      = '0;
    alu_b      = '0;

    case (state_q)
      IDLE: begin
        // Gated by rst_n so ready drops the instant reset asserts.
        req0_ready = grant0 & rst_n;
        req1_ready = grant1 & rst_n;
        if (grant0 | grant1) begin
          sel_d = grant1;
          ptr_d = grant1;
          op_d  = grant1 ? req1_op : req0_op;
          a_d   = grant1 ? req1_a  : req0_a;
          b_d   = grant1 ? req1_b  : req0_b;
          cnt_d = '0;
          if (op_d[3]) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        alu_ctrl = op_q;
        alu_a    = a_q;
        alu_b    = b_q;
        if (cnt_q == LAST_CNT) begin
          data_d  = alu_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        rsp0_valid = ~sel_q;
        rsp1_valid = sel_q;
        if (sel_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp0_data = data_q;
  assign rsp1_data = data_q;
  assign rsp0_err  = err_q;
  assign rsp1_err  = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: instance a runs with ALU_LAT=1, instance b with ALU_LAT=3, each behind a simple ALU stub.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic        a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
  logic        a_rsp0_valid, a_rsp0_ready, a_rsp0_err, a_rsp1_valid, a_rsp1_ready, a_rsp1_err, a_busy;
  logic [3:0]  a_req0_op, a_req1_op, a_alu_ctrl;
  logic [31:0] a_req0_a, a_req0_b, a_req1_a, a_req1_b, a_rsp0_data, a_rsp1_data;
  logic [31:0] a_alu_a, a_alu_b, a_alu_result;

  logic        b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic        b_rsp0_valid, b_rsp0_ready, b_rsp0_err, b_rsp1_valid, b_rsp1_ready, b_rsp1_err, b_busy;
  logic [3:0]  b_req0_op, b_req1_op, b_alu_ctrl;
  logic [31:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b, b_rsp0_data, b_rsp1_data;
  logic [31:0] b_alu_a, b_alu_b, b_alu_result;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'd0:    return ~x;
      4'd1:    return x & y;
      4'd2:    return x ^ y;
      4'd3:    return x | y;
      4'd4:    return x - 32'd1;
      4'd5:    return x + y;
      4'd6:    return x - y;
      4'd7:    return x + 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  assign a_alu_result = alu_f(a_alu_ctrl, a_alu_a, a_alu_b);
  assign b_alu_result = alu_f(b_alu_ctrl, b_alu_a, b_alu_b);

  alu_share_arbiter #(.WIDTH(32), .ALU_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_op(a_req0_op), .req0_a(a_req0_a), .req0_b(a_req0_b),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_op(a_req1_op), .req1_a(a_req1_a), .req1_b(a_req1_b),
    .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready), .rsp0_data(a_rsp0_data), .rsp0_err(a_rsp0_err),
    .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready), .rsp1_data(a_rsp1_data), .rsp1_err(a_rsp1_err),
    .alu_ctrl(a_alu_ctrl), .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_result(a_alu_result), .busy(a_busy)
  );

  alu_share_arbiter #(.WIDTH(32), .ALU_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op), .req0_a(b_req0_a), .req0_b(b_req0_b),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op), .req1_a(b_req1_a), .req1_b(b_req1_b),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_data(b_rsp0_data), .rsp0_err(b_rsp0_err),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_data(b_rsp1_data), .rsp1_err(b_rsp1_err),
    .alu_ctrl(b_alu_ctrl), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_result(b_alu_result), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req0_valid = 1'b1; a_req0_op = 4'd0; a_req0_a = '0; a_req0_b = '0;
    a_req1_valid = 1'b0; a_req1_op = 4'd0; a_req1_a = '0; a_req1_b = '0;
    a_rsp0_ready = 1'b0; a_rsp1_ready = 1'b0;
    b_req0_valid = 1'b1; b_req0_op = 4'd0; b_req0_a = '0; b_req0_b = '0;
    b_req1_valid = 1'b1; b_req1_op = 4'd0; b_req1_a = '0; b_req1_b = '0;
    b_rsp0_ready = 1'b0; b_rsp1_ready = 1'b0;

    // Reset state with requests pending
    repeat (2) step();
    #1;
    chk("rst_a_rdy0", a_req0_ready, 0);
    chk("rst_b_rdy0", b_req0_ready, 0);
    chk("rst_b_rdy1", b_req1_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ctrl", a_alu_ctrl, 0);
    chk("rst_alu_a", a_alu_a, 0);
    chk("rst_rspv", a_rsp0_valid, 0);
    chk("rst_data", a_rsp0_data, 0);
    chk("rst_err", a_rsp0_err, 0);
    a_req0_valid = 1'b0; b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    rst_n = 1'b1;

    // ADD 5+7 on requester 0, accepted on first edge after reset release
    a_req0_valid = 1'b1; a_req0_op = 4'b0101; a_req0_a = 32'd5; a_req0_b = 32'd7; a_rsp0_ready = 1'b1;
    #1 chk("add_rdy", a_req0_ready, 1);
    step();
    a_req0_valid = 1'b0; a_req0_a = 32'd99; a_req0_op = 4'hF;
    #1;
    chk("add_ctrl", a_alu_ctrl, 4'b0101);
    chk("add_alu_a", a_alu_a, 5);
    chk("add_alu_b", a_alu_b, 7);
    chk("add_busy", a_busy, 1);
    chk("add_early_v", a_rsp0_valid, 0);
    step();
    #1;
    chk("add_rspv", a_rsp0_valid, 1);
    chk("add_data", a_rsp0_data, 12);
    chk("add_err", a_rsp0_err, 0);
    chk("add_ctrl_idle", a_alu_ctrl, 0);
    chk("add_rsp1v", a_rsp1_valid, 0);
    step();
    #1;
    chk("add_done_v", a_rsp0_valid, 0);
    chk("add_done_busy", a_busy, 0);

    // Illegal op on requester 1
    a_req1_valid = 1'b1; a_req1_op = 4'b1111; a_req1_a = 32'd3; a_req1_b = 32'd4; a_rsp1_ready = 1'b1;
    #1;
    chk("ill_rdy1", a_req1_ready, 1);
    chk("ill_rdy0", a_req0_ready, 0);
    step();
    a_req1_valid = 1'b0;
    #1;
    chk("ill_rspv", a_rsp1_valid, 1);
    chk("ill_data", a_rsp1_data, 0);
    chk("ill_err", a_rsp1_err, 1);
    chk("ill_ctrl", a_alu_ctrl, 0);
    chk("ill_rsp0v", a_rsp0_valid, 0);
    step();
    #1 chk("ill_idle", a_busy, 0);

    // Continuous contention: AND on req0 (0x30), XOR on req1 (0xCC), alternating grants
    a_req0_valid = 1'b1; a_req0_op = 4'd1; a_req0_a = 32'hF0; a_req0_b = 32'h3C;
    a_req1_valid = 1'b1; a_req1_op = 4'd2; a_req1_a = 32'hF0; a_req1_b = 32'h3C;
    for (int i = 0; i < 4; i++) begin
      bit e;
      e = (i % 2) == 1;
      #1;
      chk("rr_rdy0", a_req0_ready, {31'd0, ~e});
      chk("rr_rdy1", a_req1_ready, {31'd0, e});
      step();
      #1 chk("rr_ctrl", a_alu_ctrl, e ? 32'd2 : 32'd1);
      step();
      #1;
      chk("rr_rsp0v", a_rsp0_valid, {31'd0, ~e});
      chk("rr_rsp1v", a_rsp1_valid, {31'd0, e});
      chk("rr_data", e ? a_rsp1_data : a_rsp0_data, e ? 32'hCC : 32'h30);
      step();
    end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;

    // ALU_LAT=3: SUB 10-3 on req0 with stalled response, req1 waiting
    b_req0_valid = 1'b1; b_req0_op = 4'b0110; b_req0_a = 32'd10; b_req0_b = 32'd3;
    b_req1_valid = 1'b1; b_req1_op = 4'b0111; b_req1_a = 32'd1; b_req1_b = 32'd0;
    #1;
    chk("l3_rdy0", b_req0_ready, 1);
    chk("l3_rdy1", b_req1_ready, 0);
    step();
    b_req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("l3_ctrl", b_alu_ctrl, 4'b0110);
      chk("l3_alu_a", b_alu_a, 10);
      chk("l3_alu_b", b_alu_b, 3);
      chk("l3_busy", b_busy, 1);
      chk("l3_rdy1_x", b_req1_ready, 0);
      chk("l3_early_v", b_rsp0_valid, 0);
      step();
    end
    b_rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("l3_rspv", b_rsp0_valid, 1);
      chk("l3_data", b_rsp0_data, 7);
      chk("l3_err", b_rsp0_err, 0);
      chk("l3_busy_r", b_busy, 1);
      chk("l3_rdy1_r", b_req1_ready, 0);
      chk("l3_rsp1v", b_rsp1_valid, 0);
      chk("l3_ctrl_r", b_alu_ctrl, 0);
      step();
    end
    b_rsp0_ready = 1'b1;
    #1 chk("l3_hs_v", b_rsp0_valid, 1);
    step();
    b_rsp0_ready = 1'b0;
    #1;
    chk("l3_after_busy", b_busy, 0);
    chk("l3_after_v", b_rsp0_valid, 0);
    chk("l3_rdy1_now", b_req1_ready, 1);
    step();
    #1 chk("inc_ctrl", b_alu_ctrl, 4'b0111);

    // Asynchronous reset in the middle of EXEC
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ctrl", b_alu_ctrl, 0);
    chk("ar_alu_a", b_alu_a, 0);
    chk("ar_busy", b_busy, 0);
    chk("ar_rdy1", b_req1_ready, 0);
    chk("ar_rsp1v", b_rsp1_valid, 0);
    chk("ar_data", b_rsp1_data, 0);
    chk("ar_err", b_rsp1_err, 0);
    chk("ar_a_busy", a_busy, 0);
    b_req1_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("ar_no_rsp", b_rsp1_valid, 0);
      step();
    end
    b_req0_valid = 1'b1; b_req1_valid = 1'b1;
    #1;
    chk("ar_cont_rdy0", b_req0_ready, 1);
    chk("ar_cont_rdy1", b_req1_ready, 0);
    step();
    b_req0_valid = 1'b0; b_req1_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
